// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write bus of the loader
interface imem_loader_if #(
    parameter int D = 12,
    parameter int W = 9
);
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         imem_wr_en;
    logic [D-1:0] imem_addr;
    logic [W-1:0] imem_wr_data;

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_wr_en, imem_addr, imem_wr_data
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_wr_en, imem_addr, imem_wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - packs a length-prefixed byte stream into 9-bit words written from address 0
module imem_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_req,
    imem_loader_if.slave  bus,
    output logic          core_start,
    input  logic          core_done,
    output logic          busy,
    output logic          err
);
    typedef enum logic [3:0] {
        IDLE, CNT_LO, CNT_HI, INS_LO, INS_HI, WRITE, RELEASE, RUN, ERR
    } state_t;

    localparam logic [D:0] ONE = {{D{1'b0}}, 1'b1};

    state_t      state, nxt;
    logic [7:0]  cnt_lo;
    logic [7:0]  ins_lo;
    logic [D:0]  count;
    logic [D:0]  index;
    logic [15:0] hdr;
    logic        xfer;
    logic        unused_done;

    // The core's done flag is observed only; the loader never reacts to it.
    assign unused_done = core_done;
    assign xfer        = bus.in_valid && bus.in_ready;
    assign hdr         = {bus.in_data, cnt_lo};

    always_comb begin
        nxt = state;
        case (state)
            IDLE, RUN, ERR: if (load_req) nxt = CNT_LO;
            CNT_LO:         if (xfer) nxt = CNT_HI;
            CNT_HI: begin
                if (xfer) begin
                    if ({1'b0, hdr} > (17'd1 << D)) nxt = ERR;
                    else if (hdr == 16'd0)          nxt = RELEASE;
                    else                            nxt = INS_LO;
                end
            end
            INS_LO:         if (xfer) nxt = INS_HI;
            INS_HI:         if (xfer) nxt = (bus.in_data[7:1] != 7'd0) ? ERR : WRITE;
            WRITE:          nxt = (index + ONE == count) ? RELEASE : INS_LO;
            RELEASE:        nxt = RUN;
            default:        nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt_lo           <= '0;
            ins_lo           <= '0;
            count            <= '0;
            index            <= '0;
            bus.in_ready     <= 1'b0;
            bus.imem_wr_en   <= 1'b0;
            bus.imem_addr    <= '0;
            bus.imem_wr_data <= '0;
            core_start       <= 1'b1;
            busy             <= 1'b0;
            err              <= 1'b0;
        end else begin
            state <= nxt;
            if (state == CNT_LO && xfer) cnt_lo <= bus.in_data;
            if (state == CNT_HI && xfer) begin
                count <= hdr[D:0];
                index <= '0;
            end
            if (state == INS_LO && xfer) ins_lo <= bus.in_data;
            if (state == WRITE) index <= index + ONE;

            bus.in_ready   <= (nxt inside {CNT_LO, CNT_HI, INS_LO, INS_HI});
            bus.imem_wr_en <= (nxt == WRITE);
            if (nxt == WRITE) begin
                bus.imem_addr    <= index[D-1:0];
                bus.imem_wr_data <= W'({bus.in_data[0], ins_lo});
            end
            core_start <= (nxt != RUN);
            busy       <= (nxt inside {CNT_LO, CNT_HI, INS_LO, INS_HI, WRITE, RELEASE});
            err        <= (nxt == ERR);
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a stream-parsing model
module tb_imem_loader;
    localparam int D = 12;
    localparam int W = 9;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] wr_q_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_req = 1'b0;
    logic core_done = 1'b0;
    logic core_start, busy, err;

    imem_loader_if #(.D(D), .W(W)) bus ();

    imem_loader #(.D(D), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_req   (load_req),
        .bus        (bus),
        .core_start (core_start),
        .core_done  (core_done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    wr_q_t got_wr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.imem_wr_en) begin
            got_wr.push_back(32'({bus.imem_addr, bus.imem_wr_data}));
            check("ready_in_write", 32'(bus.in_ready), 32'd0);
        end
    end

    // Reference: parse the stream by its rules, yielding the writes, bytes consumed and outcome.
    task automatic model(input byte_q_t bytes, output wr_q_t exp_wr, output int consumed,
                         output bit exp_err, output bit zero_n);
        logic [15:0] n;
        logic [7:0]  lo, hi;
        exp_wr = {};
        exp_err = 1'b0;
        n = {bytes[1], bytes[0]};
        consumed = 2;
        zero_n = (n == 16'd0);
        if (n > 16'd4096) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            lo = bytes[2 + 2*i];
            hi = bytes[3 + 2*i];
            consumed += 2;
            if (hi[7:1] != 7'd0) begin
                exp_err = 1'b1;
                return;
            end
            exp_wr.push_back((32'(i) << 9) | 32'({hi[0], lo}));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        check("byte_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        check("load_err_clr", 32'(err), 32'd0);
        check("load_busy", 32'(busy), 32'd1);
        check("load_start", 32'(core_start), 32'd1);
    endtask

    // mode 0: in_valid held high, 1: two idle cycles before every byte, 2: random gaps
    task automatic run_load(input string name, input byte_q_t bytes, input int mode);
        wr_q_t exp_wr;
        int    consumed, lat, gap;
        bit    exp_err, zero_n;
        model(bytes, exp_wr, consumed, exp_err, zero_n);
        got_wr = {};
        pulse_load();
        for (int i = 0; i < consumed; i++) begin
            gap = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 3));
            send_byte(bytes[i], gap);
        end
        if (!exp_err) begin
            lat = 0;
            while (core_start && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check({name, "_start_lat"}, 32'(lat), zero_n ? 32'd1 : 32'd2);
            check({name, "_busy_fall"}, 32'(busy), 32'd0);
        end else begin
            check({name, "_err_now"}, 32'(err), 32'd1);
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_nwrites"}, 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check($sformatf("%s_wr%0d", name, i), got_wr[i], exp_wr[i]);
        check({name, "_err"}, 32'(err), 32'(exp_err));
        check({name, "_start"}, 32'(core_start), 32'(exp_err));
        check({name, "_ready"}, 32'(bus.in_ready), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        byte_q_t basic, q;
        int      n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_start", 32'(core_start), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wr_en", 32'(bus.imem_wr_en), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_start", 32'(core_start), 32'd1);
            check("idle_busy", 32'(busy | bus.in_ready | err | bus.imem_wr_en), 32'd0);
        end
        @(posedge clk);
        #1;

        basic = {8'h03, 8'h00, 8'h5A, 8'h00, 8'hFF, 8'h01, 8'h07, 8'h00};
        run_load("basic", basic, 0);
        run_load("stall", basic, 1);
        run_load("fmt_err", {8'h02, 8'h00, 8'h11, 8'h00, 8'h22, 8'h04}, 0);
        run_load("n_zero", {8'h00, 8'h00}, 0);
        run_load("n_4097", {8'h01, 8'h10}, 2);

        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 24));
            q = {8'(n), 8'h00};
            for (int i = 0; i < n; i++) begin
                q.push_back(8'($urandom));
                if ($urandom_range(0, 19) == 0) q.push_back(8'($urandom));
                else q.push_back({7'd0, 1'($urandom)});
            end
            run_load($sformatf("rnd%0d", r), q, int'($urandom_range(0, 2)));
        end

        q = {8'h00, 8'h10};
        for (int i = 0; i < 4096; i++) begin
            q.push_back(8'($urandom));
            q.push_back({7'd0, 1'($urandom)});
        end
        run_load("n_4096", q, 0);
        if (got_wr.size() > 0)
            check("n_4096_last_addr", got_wr[got_wr.size()-1] >> 9, 32'hFFF);

        got_wr = {};
        pulse_load();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h00, 0);
        send_byte(8'h22, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_start", 32'(core_start), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_wr_en", 32'(bus.imem_wr_en), 32'd0);
        check("mid_rst_addr", 32'(bus.imem_addr), 32'd0);
        check("mid_rst_data", 32'(bus.imem_wr_data), 32'd0);
        check("mid_rst_nwrites", 32'(got_wr.size()), 32'd1);
        if (got_wr.size() > 0) check("mid_rst_wr0", got_wr[0], 32'h011);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_load("after_rst", basic, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory interface. It receives a program as a byte stream over a valid/ready handshake and packs each pair of bytes into one 9-bit machine-code word. Words are written to consecutive instruction-memory addresses starting at 0. The block holds the core parked (start high) while loading, releases it when loading finishes, and then reports load/run status.

Parameters:
D, 12, instruction address width; matches the core's program-counter width.
W, 9, machine-code word width.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
load_req  input  1  one-cycle request to begin a load; sampled only in IDLE, RUN or ERR.
in_valid  input  1  byte-stream valid.
in_data  input  8  byte-stream data.
in_ready  output  1  byte-stream ready; a byte transfers when in_valid && in_ready.
imem_wr_en  output  1  instruction-memory write strobe, one cycle per word.
imem_addr  output  D  instruction-memory write address.
imem_wr_data  output  W  instruction word being written.
core_start  output  1  drives the core's start input; high holds the PC at start_address 0.
core_done  input  1  core's done flag.
busy  output  1  high while a load is in progress.
err  output  1  sticky format error.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - in_ready=0, imem_wr_en=0, imem_addr=0, imem_wr_data=0.
  - core_start=1, busy=0, err=0.
  - Internal count/index registers cleared.
- States: IDLE, CNT_LO, CNT_HI, INS_LO, INS_HI, WRITE, RELEASE, RUN, ERR.
- IDLE: core_start=1. On load_req go to CNT_LO and clear err.
- Header, two bytes, little-endian word count N (16 bits):
  - CNT_LO captures N[7:0]; CNT_HI captures N[15:8].
  - N > 2**D: go to ERR.
  - N == 0: go to RELEASE.
  - Otherwise go to INS_LO with index=0.
- INS_LO captures the low byte, which becomes word[7:0].
- INS_HI captures the high byte; bit0 becomes word[8].
  - If high byte bits[7:1] != 0: go to ERR, with no write for that word.
  - Otherwise go to WRITE.
- WRITE, exactly one cycle:
  - imem_wr_en=1, imem_addr=index, imem_wr_data=word.
  - Then index+1. If index+1 == N go to RELEASE, else go to INS_LO.
  - imem_wr_en is 0 in every other state.
- in_ready=1 only in CNT_LO, CNT_HI, INS_LO and INS_HI. in_ready does not depend combinationally on in_valid.
- A state advances only on a completed transfer; in_valid low stalls indefinitely with no timeout.
- busy=1 in CNT_LO through WRITE and in RELEASE.
- RELEASE: core_start stays 1 for this one cycle, then go to RUN.
- RUN: core_start=0. core_done is observed only; the loader takes no action on it.
- load_req in RUN: core_start=1 on the next cycle, then go to CNT_LO. Memory is overwritten from address 0.
- ERR:
  - err=1, core_start=1, in_ready=0.
  - Words already written stay in memory.
  - Exit only via load_req, which goes to CNT_LO and clears err, or via reset.
- load_req in any state other than IDLE, RUN or ERR is ignored.
- Address arithmetic: index is D+1 bits so that N = 2**D is representable. imem_addr = index[D-1:0] and never wraps within a load.
- Reset mid-load: everything returns to reset values immediately and asynchronously. A partial program is left in memory, and core_start is forced to 1.
- Byte throughput: at most 2 bytes per 3 cycles per word, because WRITE inserts one bubble with in_ready=0.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then high. Required: in_ready=0, core_start=1, busy=0, err=0. With no load_req, nothing changes for 20 cycles.
- Basic load: load_req, then bytes 03 00 | 5A 00 | FF 01 | 07 00 with in_valid held high.
  - Three imem_wr_en pulses: (addr 0, 0x05A), (addr 1, 0x1FF), (addr 2, 0x007).
  - core_start stays 1 through RELEASE and goes 0 the cycle after.
  - busy falls with it and err=0.
- Backpressure/stall: same stream with in_valid toggling 1-0-0-1. Required: identical writes. in_ready=0 during each WRITE cycle, and no byte is lost or duplicated.
- Format error: header 02 00, then 11 00 | 22 04.
  - One write: (0, 0x011).
  - After the 0x04 byte: ERR with err=1, core_start=1, no second write.
  - A following load_req clears err.
- Boundaries:
  - N=0 (bytes 00 00): no writes, and core_start goes 0 two cycles after the last header byte.
  - N=4097 (01 10): ERR with no writes.
  - N=4096: last write at addr 0xFFF, then RELEASE.
- Reset mid-load: assert rst_n low during INS_HI of word 1. Required: all outputs at reset values asynchronously, before the next clk edge. Word 0 stays written, and the next load_req restarts at addr 0.
